lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port lbp_valid, input, 1 bit: an LBP sample is present this cycle; there is no backpressure to the source.
REQ-005 SHALL have port lbp_addr, input, 14 bits: sample pixel address {y[6:0], x[6:0]}.
REQ-006 SHALL have port lbp_data, input, 8 bits: LBP code, used as the bin index.
REQ-007 SHALL have port finish, input, 1 bit: one-cycle pulse marking the end of the image.
REQ-008 SHALL have port hist_valid, output, 1 bit: hist_bin/hist_count hold a valid dump beat.
REQ-009 SHALL have port hist_ready, input, 1 bit: consumer accepts the dump beat.
REQ-010 SHALL have port hist_bin, output, 8 bits: index of the bin being dumped.
REQ-011 SHALL have port hist_count, output, 14 bits: count of the bin being dumped.
REQ-012 SHALL have port hist_done, output, 1 bit: one-cycle pulse after the last bin is accepted.
REQ-013 SHALL have port pix_cnt, output, 14 bits: interior samples counted in the current image.
REQ-014 SHALL have port drop_err, output, 1 bit: sticky flag set when a sample is dropped.

Function
REQ-015 SHALL keep 256 bins, each 14 bits wide.
REQ-016 SHALL implement FSM states ACCUM, DUMP and DONE.
REQ-017 SHALL use these transitions: ACCUM->DUMP on finish; DUMP->DONE when hist_valid&&hist_ready&&hist_bin==255; DONE->ACCUM unconditionally after 1 cycle.
REQ-018 SHALL, in ACCUM with lbp_valid=1 and an interior address (x in 1..126 and y in 1..126), increment bin[lbp_data] and pix_cnt on the next edge.
REQ-019 SHALL ignore samples in ACCUM whose address has x or y equal to 0 or 127, without counting them and without setting drop_err.
REQ-020 SHALL saturate each bin and pix_cnt at 16383, with no wrap.
REQ-021 SHALL, when lbp_valid and finish occur in the same ACCUM cycle, count the sample first and then enter DUMP.
REQ-022 SHALL drive hist_valid=1 throughout DUMP and 0 in every other state.
REQ-023 SHALL combinationally drive hist_count = bin[hist_bin].
REQ-024 SHALL hold hist_bin and hist_count stable while hist_valid=1 and hist_ready=0.
REQ-025 SHALL start the dump at hist_bin=0 and, on each beat accepted by hist_ready, clear bin[hist_bin] to 0 and increment hist_bin.
REQ-026 SHALL wrap hist_bin from 255 to 0 on the final accepted beat.
REQ-027 SHALL assert hist_done for exactly 1 cycle in DONE.
REQ-028 SHALL clear pix_cnt to 0 on the DONE->ACCUM transition.
REQ-029 SHALL, in DUMP or DONE, discard any lbp_valid sample and set drop_err to 1; drop_err holds until reset.
REQ-030 SHALL ignore finish when the FSM is in DUMP or DONE.
REQ-031 SHALL complete a dump with continuous hist_ready in 256 cycles, plus 1 cycle for DONE.

Reset
REQ-032 SHALL, while reset=0 at a clk edge, set the FSM to ACCUM and clear all 256 bins, hist_bin, pix_cnt and drop_err to 0.
REQ-033 SHALL hold hist_valid=0, hist_done=0 and hist_count=0 during reset.
REQ-034 SHALL abandon any dump or accumulation interrupted by reset, with no residual counts.
REQ-035 SHALL have no reset-dependent combinational path other than through the registered state.

Verification
REQ-036 SHALL pass: 3 interior samples with code 0x5A, then finish, hist_ready=1 -> beat 0x5A shows count 3, all other bins 0, pix_cnt=3 before DONE, hist_done pulses 257 cycles after finish.
REQ-037 SHALL pass: samples at addr {0,5}, {5,127} and {1,1} with code 7 -> bin 7 = 1, pix_cnt=1, drop_err=0.
REQ-038 SHALL pass: hist_ready toggled 1,0,0,1 during the dump -> hist_bin advances only on ready cycles, values held while stalled, 256 beats total.
REQ-039 SHALL pass: a full 126x126 raster with all codes 0xFF -> bin 255 = 15876, pix_cnt=15876; a second image after DONE starts from zeroed bins.
REQ-040 SHALL pass: lbp_valid asserted while in DUMP -> sample not counted, drop_err=1 until reset; finish in DUMP has no effect.
REQ-041 SHALL pass: reset=0 mid-dump at bin 100 -> next cycle the FSM is in ACCUM, hist_valid=0, and a following dump shows all 256 bins at 0.

Source files
------------

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin LBP code histogram with handshaked dump and auto-clear.
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset
//   lbp_valid  - sample present (no backpressure)
//   lbp_addr   - sample address {y[6:0], x[6:0]}
//   lbp_data   - LBP code, used as bin index
//   finish     - end-of-image pulse, starts the dump
//   hist_valid - dump beat valid (high throughout DUMP)
//   hist_ready - consumer accepts the dump beat
//   hist_bin   - bin index of the current beat
//   hist_count - count of the current bin
//   hist_done  - one-cycle pulse after the last beat
//   pix_cnt    - interior samples counted in this image
//   drop_err   - sticky: a sample arrived while not accumulating
module lbp_hist (
    input  logic        clk,
    input  logic        reset,
    input  logic        lbp_valid,
    input  logic [13:0] lbp_addr,
    input  logic [7:0]  lbp_data,
    input  logic        finish,
    output logic        hist_valid,
    input  logic        hist_ready,
    output logic [7:0]  hist_bin,
    output logic [13:0] hist_count,
    output logic        hist_done,
    output logic [13:0] pix_cnt,
    output logic        drop_err
);
    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] DUMP  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [7:0]         r_hist_bin;
    logic [13:0]        r_pix_cnt;
    logic               r_drop_err;
    logic [255:0][13:0] w_bins;
    logic               w_interior;
    logic               w_acc;
    logic               w_beat;
    logic [1:0]         w_next;

    // border pixels (x or y at 0 or 127) have no full neighbourhood
    assign w_interior = lbp_addr[6:0] != 7'd0 && lbp_addr[6:0] != 7'd127 &&
                        lbp_addr[13:7] != 7'd0 && lbp_addr[13:7] != 7'd127;
    assign w_acc  = r_state == ACCUM && lbp_valid && w_interior;
    assign w_beat = r_state == DUMP && hist_ready;
    assign w_next = r_state == ACCUM ? (finish ? DUMP : ACCUM) :
                    r_state == DUMP  ? ((w_beat && r_hist_bin == 8'hFF) ? DONE : DUMP) :
                    ACCUM;

    // each bin is its own saturating counter, cleared as its dump beat is accepted
    for (genvar b = 0; b < 256; b++) begin : g_bin
        logic [13:0] r_cnt;
        always_ff @(posedge clk) begin
            if (!reset || (w_beat && r_hist_bin == 8'(b)))
                r_cnt <= '0;
            else if (w_acc && lbp_data == 8'(b) && r_cnt != 14'h3FFF)
                r_cnt <= r_cnt + 14'd1;
        end
        assign w_bins[b] = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ACCUM;
            r_hist_bin <= '0;
            r_pix_cnt  <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_beat)
                r_hist_bin <= r_hist_bin + 8'd1;
            if (r_state == DONE)
                r_pix_cnt <= '0;
            else if (w_acc && r_pix_cnt != 14'h3FFF)
                r_pix_cnt <= r_pix_cnt + 14'd1;
            if (r_state != ACCUM && lbp_valid)
                r_drop_err <= 1'b1;
        end
    end

    assign hist_valid = r_state == DUMP;
    assign hist_done  = r_state == DONE;
    assign hist_bin   = r_hist_bin;
    assign hist_count = w_bins[r_hist_bin];
    assign pix_cnt    = r_pix_cnt;
    assign drop_err   = r_drop_err;
endmodule

// File: tb/tb_lbp_hist.sv
// tb_lbp_hist: directed + randomized self-checking bench for lbp_hist.
module tb_lbp_hist;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        hist_valid;
    logic        hist_ready = 1'b0;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count;
    logic        hist_done;
    logic [13:0] pix_cnt;
    logic        drop_err;

    int n_tests = 0;
    int n_fail = 0;
    int m_bin[256];
    int m_pix = 0;
    bit m_drop = 0;
    bit m_accum = 1;
    int cyc;

    lbp_hist dut (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
        .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
        .hist_done(hist_done), .pix_cnt(pix_cnt), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit interior(input int a);
        int x = a % 128;
        int y = a / 128;
        return x >= 1 && x <= 126 && y >= 1 && y <= 126;
    endfunction

    function automatic void model_clear();
        foreach (m_bin[i]) m_bin[i] = 0;
        m_pix = 0;
    endfunction

    task automatic send(input bit v, input int a, input int d, input bit f);
        lbp_valid = v;
        lbp_addr = 14'(a);
        lbp_data = 8'(d);
        finish = f;
        tick();
        if (v && !m_accum) m_drop = 1;
        if (v && m_accum && interior(a)) begin
            m_bin[d] = m_bin[d] < 16383 ? m_bin[d] + 1 : 16383;
            m_pix = m_pix < 16383 ? m_pix + 1 : 16383;
        end
        if (f) m_accum = 0;
        lbp_valid = 0;
        finish = 0;
    endtask

    // mode 0: ready always, 1: pattern 1,0,0,1, 2: random ready
    task automatic do_dump(input int mode, output int cycles);
        int idx = 0;
        bit rdy;
        cycles = 0;
        while (idx < 256 && cycles < 3000) begin
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (cycles % 4 == 0 || cycles % 4 == 3) : 1'($urandom_range(0, 1));
            hist_ready = rdy;
            check("dump_valid", hist_valid, 1);
            check("dump_bin", hist_bin, idx);
            check("dump_count", hist_count, m_bin[idx]);
            check("dump_no_done", hist_done, 0);
            tick();
            cycles++;
            if (rdy) idx++;
        end
        hist_ready = 0;
        check("dump_beats", idx, 256);
        check("done_pulse", hist_done, 1);
        check("done_valid_low", hist_valid, 0);
        check("bin_wrap", hist_bin, 0);
        check("pix_in_done", pix_cnt, m_pix);
        tick();
        check("done_once", hist_done, 0);
        check("pix_cleared", pix_cnt, 0);
        check("accum_valid_low", hist_valid, 0);
        model_clear();
        m_accum = 1;
    endtask

    initial begin
        model_clear();
        // reset state
        reset = 0;
        tick();
        tick();
        check("rst_valid", hist_valid, 0);
        check("rst_done", hist_done, 0);
        check("rst_count", hist_count, 0);
        check("rst_pix", pix_cnt, 0);
        check("rst_drop", drop_err, 0);
        reset = 1;
        tick();

        // three 0x5A samples, continuous ready, DONE latency
        for (int i = 0; i < 3; i++)
            send(1, $urandom_range(1, 126) * 128 + $urandom_range(1, 126), 8'h5A, 0);
        check("pix_three", pix_cnt, 3);
        send(0, 0, 0, 1);
        do_dump(0, cyc);
        check("done_latency", cyc + 1, 257);

        // border samples ignored, valid+finish in same cycle counts first, stalled dump
        send(1, 0 * 128 + 5, 7, 0);
        send(1, 5 * 128 + 127, 7, 0);
        check("border_pix", pix_cnt, 0);
        send(1, 1 * 128 + 1, 7, 1);
        check("border_drop", drop_err, 0);
        check("same_cycle_pix", pix_cnt, 1);
        do_dump(1, cyc);

        // randomized image including border addresses, random ready
        for (int i = 0; i < 300; i++)
            send($urandom_range(0, 3) != 0, $urandom_range(0, 16383), $urandom_range(0, 255), 0);
        check("rand_pix", pix_cnt, m_pix);
        send(0, 0, 0, 1);
        do_dump(2, cyc);

        // samples and finish during DUMP are dropped/ignored
        for (int i = 0; i < 5; i++)
            send(1, $urandom_range(1, 126) * 128 + $urandom_range(1, 126), $urandom_range(0, 3), 0);
        send(0, 0, 0, 1);
        send(1, 10 * 128 + 10, 8'h10, 1);
        check("dump_drop_err", drop_err, 1);
        check("dump_finish_bin", hist_bin, 0);
        check("dump_finish_valid", hist_valid, 1);
        do_dump(0, cyc);
        check("drop_sticky", drop_err, m_drop);

        // full raster of 0xFF, then push both counters into saturation
        for (int y = 1; y <= 126; y++)
            for (int x = 1; x <= 126; x++)
                send(1, y * 128 + x, 8'hFF, 0);
        check("raster_pix", pix_cnt, 15876);
        check("raster_model", m_bin[255], 15876);
        for (int i = 0; i < 600; i++)
            send(1, 64 * 128 + 64, 8'hFF, 0);
        check("sat_pix", pix_cnt, 16383);
        send(0, 0, 0, 1);
        do_dump(0, cyc);
        send(1, 2 * 128 + 3, 8'h01, 0);
        send(1, 3 * 128 + 2, 8'hFF, 1);
        do_dump(2, cyc);
        check("drop_still", drop_err, 1);

        // reset mid-dump at bin 100 leaves no residue
        for (int i = 0; i < 20; i++)
            send(1, $urandom_range(1, 126) * 128 + $urandom_range(1, 126), $urandom_range(0, 255), 0);
        send(0, 0, 0, 1);
        hist_ready = 1;
        repeat (100) tick();
        hist_ready = 0;
        check("mid_bin", hist_bin, 100);
        check("mid_valid", hist_valid, 1);
        reset = 0;
        tick();
        check("mrst_valid", hist_valid, 0);
        check("mrst_done", hist_done, 0);
        check("mrst_count", hist_count, 0);
        check("mrst_bin", hist_bin, 0);
        check("mrst_pix", pix_cnt, 0);
        check("mrst_drop", drop_err, 0);
        reset = 1;
        model_clear();
        m_accum = 1;
        m_drop = 0;
        tick();
        send(0, 0, 0, 1);
        do_dump(0, cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
